// File: rtl/peripheral_subtractor.sv
// rtl/peripheral_subtractor.sv - two-stage elastic unsigned subtractor with borrow and delivery counter (optional PERIPHERAL_SUBTRACTOR_SATURATE_EN)
module peripheral_subtractor #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  in1,
  input  logic [DATA_WIDTH-1:0]  in2,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH:0]    out,
  output logic                   borrow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] count
);

  // Stage A: captured operand pair
  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_in1;
  logic [DATA_WIDTH-1:0] a_in2;

  logic                  in_fire;
  logic                  out_fire;
  logic                  a_move;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   result;

  // Held low during reset so nothing is accepted before the pipeline is cleared.
  assign in_ready = !rst && (!a_valid || !out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // A may advance whenever B is empty or is being emptied on this edge.
  assign a_move   = a_valid && (!out_valid || out_ready);

  // One extra bit so the top bit of the difference is the borrow.
  assign diff = {1'b0, a_in1} - {1'b0, a_in2};

`ifdef PERIPHERAL_SUBTRACTOR_SATURATE_EN
  assign result = diff[DATA_WIDTH] ? '0 : diff;
`else
  assign result = diff;
`endif

  // Stage A occupancy: set on accept, cleared when the pair moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
    end else if (in_fire) begin
      a_valid <= 1'b1;
    end else if (a_move) begin
      a_valid <= 1'b0;
    end
  end

  // Stage A operands are sampled only on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_in1 <= '0;
      a_in2 <= '0;
    end else if (in_fire) begin
      a_in1 <= in1;
      a_in2 <= in2;
    end
  end

  // Stage B: result register; holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      borrow    <= 1'b0;
    end else if (a_move) begin
      out_valid <= 1'b1;
      out       <= result;
      borrow    <= diff[DATA_WIDTH];
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Delivered-result counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (out_fire) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule
